// File: rtl/pdpm_rx_parser.sv
// pdpm_rx_parser: parses pDPM request frames into read/write commands and forwards write payloads.
module pdpm_rx_parser #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              rx_fifo_clock,
  input  logic              rx_fifo_resetn,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  drop_count,
  output logic              drop_pulse
);
  typedef enum logic [2:0] {HDR, CMD, PAYLOAD, DRAIN, DROP} state_t;
  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [7:0] et_hi;
  logic [31:0] addr_sr;
  logic [15:0] len_sr;
  logic is_write, drain_pending, fire, hdr_fire, drop;
  assign s_axis_tready = rx_fifo_resetn & (state == PAYLOAD ? m_axis_tready : state != CMD);
  assign fire = s_axis_tvalid & s_axis_tready;
  assign hdr_fire = state == HDR && fire;
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tvalid = rx_fifo_resetn & (state == PAYLOAD) & s_axis_tvalid;
  assign m_axis_tlast = (state == PAYLOAD) & s_axis_tlast;
  assign cmd_valid = state == CMD;
  assign cmd_write = is_write;
  assign cmd_addr = addr_sr[ADDR_W-1:0];
  assign cmd_len = len_sr[LEN_W-1:0];
  // Every way a header can be rejected; a rejected frame yields exactly one pulse.
  assign drop = hdr_fire && (
    (cnt == 5'd13 && {et_hi, s_axis_tdata} != ETHERTYPE) ||
    (cnt == 5'd14 && s_axis_tdata != 8'h01 && s_axis_tdata != 8'h02) ||
    (s_axis_tlast && cnt < 5'd20) ||
    (cnt == 5'd20 && s_axis_tlast && is_write));
  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     state_nxt = drop ? (s_axis_tlast ? HDR : DROP) : (hdr_fire && cnt == 5'd20) ? CMD : HDR;
      CMD:     state_nxt = !cmd_ready ? CMD : is_write ? PAYLOAD : drain_pending ? DRAIN : HDR;
      default: state_nxt = (fire && s_axis_tlast) ? HDR : state;
    endcase
    cnt_nxt = (state != HDR || state_nxt != HDR || (fire && s_axis_tlast)) ? 5'd0 : cnt + 5'(hdr_fire);
  end
  always_ff @(posedge rx_fifo_clock) begin
    if (!rx_fifo_resetn) begin
      state <= HDR;
      cnt <= '0;
      et_hi <= '0;
      addr_sr <= '0;
      len_sr <= '0;
      is_write <= 1'b0;
      drain_pending <= 1'b0;
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      drop_pulse <= drop;
      if (drop && ~&drop_count) drop_count <= drop_count + 1'b1;
      if (hdr_fire) begin
        if (cnt == 5'd12) et_hi <= s_axis_tdata;
        if (cnt == 5'd14) is_write <= s_axis_tdata == 8'h02;
        if (cnt >= 5'd15 && cnt <= 5'd18) addr_sr <= {addr_sr[23:0], s_axis_tdata};
        if (cnt == 5'd19 || cnt == 5'd20) len_sr <= {len_sr[7:0], s_axis_tdata};
        if (cnt == 5'd20) drain_pending <= !is_write && !s_axis_tlast;
      end
    end
  end
endmodule

// File: tb/tb_pdpm_rx_parser.sv
// tb_pdpm_rx_parser: frame-level scoreboard bench for pdpm_rx_parser, plus a CNT_W=2 copy for saturation.
module tb_pdpm_rx_parser;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, resetn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, cmd_ready = 1'b1, m_tready = 1'b1;
  logic s_axis_tready, cmd_valid, cmd_write, m_axis_tvalid, m_axis_tlast, drop_pulse;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len, drop_count;
  logic [7:0] m_axis_tdata;
  logic sat_tready, sat_cmd_valid, sat_cmd_write, sat_m_tvalid, sat_m_tlast, sat_drop_pulse;
  logic [31:0] sat_cmd_addr;
  logic [15:0] sat_cmd_len;
  logic [7:0] sat_m_tdata;
  logic [1:0] sat_drop_count;
  always #5 clk = ~clk;
  pdpm_rx_parser u_dut (
    .rx_fifo_clock(clk), .rx_fifo_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_tlast),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_axis_tlast),
    .drop_count(drop_count), .drop_pulse(drop_pulse)
  );
  pdpm_rx_parser #(.CNT_W(2)) u_sat (
    .rx_fifo_clock(clk), .rx_fifo_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sat_tready), .s_axis_tlast(s_tlast),
    .cmd_valid(sat_cmd_valid), .cmd_ready(cmd_ready), .cmd_write(sat_cmd_write), .cmd_addr(sat_cmd_addr), .cmd_len(sat_cmd_len),
    .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(sat_m_tlast),
    .drop_count(sat_drop_count), .drop_pulse(sat_drop_pulse)
  );
  int total = 0, bad = 0, pulses = 0, sat_pulses = 0, pay_beats = 0;
  int exp_drops = 0, pulse_base = 0, sat_base = 0;
  logic [48:0] exp_cmd[$];
  logic [8:0] exp_pay[$];
  logic [48:0] last_cmd = '0;
  logic [8:0] last_pay = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected or never seen", name);
  endtask
  // Frame-level model: a frame is either one command (plus payload for writes) or one drop.
  task automatic model(input bq_t f);
    int n = f.size();
    logic rej = n < 21;
    if (!rej) rej = {f[12], f[13]} != 16'h88B5 || !(f[14] == 8'h01 || f[14] == 8'h02) || (f[14] == 8'h02 && n == 21);
    if (rej) exp_drops++;
    else begin
      exp_cmd.push_back({f[14] == 8'h02, f[15], f[16], f[17], f[18], f[19], f[20]});
      if (f[14] == 8'h02) for (int i = 21; i < n; i++) exp_pay.push_back({i == n - 1, f[i]});
    end
  endtask
  task automatic mk(input logic [15:0] et, input logic [7:0] op, input logic [31:0] a, input logic [15:0] l,
                    input bq_t pay, output bq_t f);
    f = {};
    for (int i = 0; i < 12; i++) f.push_back(8'(8'h10 + i));
    f.push_back(et[15:8]); f.push_back(et[7:0]); f.push_back(op);
    f.push_back(a[31:24]); f.push_back(a[23:16]); f.push_back(a[15:8]); f.push_back(a[7:0]);
    f.push_back(l[15:8]); f.push_back(l[7:0]);
    foreach (pay[i]) f.push_back(pay[i]);
  endtask
  task automatic send_frame(input bq_t f, input int rst_at);
    for (int i = 0; i < f.size(); i++) begin
      int w = 0;
      logic acc = 1'b0;
      if (i == rst_at) begin
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        return;
      end
      s_tdata = f[i];
      s_tvalid = 1'b1;
      s_tlast = i == f.size() - 1;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        fail("s_axis_timeout");
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic checkpoint(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drop_count"}, drop_count, exp_drops > 65535 ? 65535 : exp_drops);
    chk({tag, "_sat_count"}, sat_drop_count, exp_drops > 3 ? 3 : exp_drops);
    chk({tag, "_pulses"}, pulses - pulse_base, exp_drops);
    chk({tag, "_sat_pulses"}, sat_pulses - sat_base, exp_drops);
    chk({tag, "_cmd_left"}, exp_cmd.size(), 0);
    chk({tag, "_pay_left"}, exp_pay.size(), 0);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_drop_count"}, drop_count, 0);
    chk({tag, "_sat_count"}, sat_drop_count, 0);
    chk({tag, "_drop_pulse"}, drop_pulse, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 0);
    chk({tag, "_cmd_fields"}, {cmd_write, cmd_addr, cmd_len}, 0);
  endtask
  always @(negedge clk) if (resetn) begin
    if (drop_pulse) pulses++;
    if (sat_drop_pulse) sat_pulses++;
    if (cmd_valid) begin
      chk("cmd_stall_tready", s_axis_tready, 0);
      if (exp_cmd.size() == 0) fail("cmd_unexpected");
      else begin
        chk("cmd_fields", {cmd_write, cmd_addr, cmd_len}, exp_cmd[0]);
        if (cmd_ready) begin
          last_cmd = {cmd_write, cmd_addr, cmd_len};
          void'(exp_cmd.pop_front());
        end
      end
    end
    if (m_axis_tvalid && m_tready) begin
      if (exp_pay.size() == 0) fail("payload_unexpected");
      else begin
        chk("payload_beat", {m_axis_tlast, m_axis_tdata}, exp_pay.pop_front());
        last_pay = {m_axis_tlast, m_axis_tdata};
        pay_beats++;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bq_t f, pay;
    int beats0;
    logic done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    chk("rst0_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", s_axis_tready, 1);
    @(posedge clk); #1;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mk(16'h88B5, 8'h02, 32'h0000_1000, 16'd4, pay, f);
    model(f); send_frame(f, -1);
    checkpoint("wr");
    chk("wr_cmd_literal", last_cmd, {1'b1, 32'h1000, 16'd4});
    chk("wr_last_byte", last_pay, {1'b1, 8'hEF});
    chk("wr_beats", pay_beats, 4);
    pay = {};
    for (int i = 0; i < 39; i++) pay.push_back(8'(i * 3));
    mk(16'h88B5, 8'h01, 32'h20, 16'd64, pay, f);
    chk("rd_frame_size", f.size(), 60);
    beats0 = pay_beats;
    model(f); send_frame(f, -1);
    checkpoint("rd");
    chk("rd_cmd_literal", last_cmd, {1'b0, 32'h20, 16'd64});
    chk("rd_no_payload", pay_beats - beats0, 0);
    pay = {};
    for (int i = 0; i < 9; i++) pay.push_back(8'(8'hA0 + i));
    mk(16'h0800, 8'h02, 32'h44, 16'd9, pay, f);
    model(f); send_frame(f, -1);
    mk(16'h88B5, 8'h07, 32'h44, 16'd9, pay, f);
    model(f); send_frame(f, -1);
    checkpoint("bad");
    chk("bad_drop_literal", drop_count, 2);
    chk("bad_no_payload", pay_beats - beats0, 0);
    pay = '{8'h11, 8'h22, 8'h33};
    mk(16'h88B5, 8'h02, 32'h0000_0300, 16'd3, pay, f);
    model(f); send_frame(f, -1);
    checkpoint("good_after_bad");
    chk("good_after_bad_cmd", last_cmd, {1'b1, 32'h300, 16'd3});
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    mk(16'h88B5, 8'h02, 32'h00AB_CDEF, 16'd6, pay, f);
    model(f);
    beats0 = pay_beats;
    cmd_ready = 1'b0;
    done = 1'b0;
    fork
      begin
        send_frame(f, -1);
        done = 1'b1;
      end
      begin
        int w = 0;
        while (!cmd_valid && w < 300) begin
          @(posedge clk); #1;
          w++;
        end
        if (!cmd_valid) fail("cmd_wait_timeout");
        repeat (10) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        while (!done) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    checkpoint("bp");
    chk("bp_cmd_literal", last_cmd, {1'b1, 32'h00AB_CDEF, 16'd6});
    chk("bp_beats", pay_beats - beats0, 6);
    chk("bp_last_byte", last_pay, {1'b1, 8'h06});
    pay = {};
    mk(16'h88B5, 8'h02, 32'h10, 16'd2, pay, f);
    while (f.size() > 10) void'(f.pop_back());
    model(f); send_frame(f, -1);
    checkpoint("runt");
    chk("runt_drop_literal", drop_count, 3);
    pay = '{8'h55, 8'h66};
    mk(16'h88B5, 8'h02, 32'h0000_7777, 16'd2, pay, f);
    send_frame(f, 17);
    exp_drops = 0;
    pulse_base = pulses;
    sat_base = sat_pulses;
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk); #1;
    pay = {};
    mk(16'h88B5, 8'h01, 32'h0000_0040, 16'd8, pay, f);
    model(f); send_frame(f, -1);
    checkpoint("post_rst");
    chk("post_rst_cmd", last_cmd, {1'b0, 32'h40, 16'd8});
    pay = '{8'h99, 8'h98};
    mk(16'h0806, 8'h01, 32'h1, 16'd1, pay, f);
    model(f); send_frame(f, -1);
    mk(16'h88B5, 8'hFF, 32'h1, 16'd1, pay, f);
    model(f); send_frame(f, -1);
    mk(16'h88B5, 8'h01, 32'h1, 16'd1, pay, f);
    while (f.size() > 10) void'(f.pop_back());
    model(f); send_frame(f, -1);
    pay = {};
    mk(16'h88B5, 8'h02, 32'h1, 16'd1, pay, f);
    model(f); send_frame(f, -1);
    mk(16'h1234, 8'h01, 32'h1, 16'd1, pay, f);
    while (f.size() > 14) void'(f.pop_back());
    model(f); send_frame(f, -1);
    checkpoint("sat");
    chk("sat_wide_literal", drop_count, 5);
    chk("sat_narrow_literal", sat_drop_count, 3);
    chk("sat_pulse_literal", sat_pulses - sat_base, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
